qr_mask_encode: RTL and testbench
=================================

QR_MASK_ENCODE -- requirements
Module: qr_mask_encode

Interface
REQ-001 SHALL have parameter MOD_SIZE, default 21, modules per side; only 21 (version 1) is supported.
REQ-002 SHALL have port clk_in  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port rst_in  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port start_mask  input  1  request to encode; sampled only in IDLE.
REQ-005 SHALL have port mask_id  input  3  ISO mask pattern 0-7 to apply.
REQ-006 SHALL have port ec_level  input  2  ISO EC indicator (L=01, M=00, Q=11, H=10).
REQ-007 SHALL have port qr_plain  input  441  unmasked matrix, black=0/white=1, bit address = x + y*MOD_SIZE, row = 20-x, col = y.
REQ-008 SHALL have port qr_masked  output  441  masked matrix with format info; same polarity and addressing as qr_plain.
REQ-009 SHALL have port mask_busy  output  1  high while an encode is in progress.
REQ-010 SHALL have port mask_done  output  1  one-cycle pulse; qr_masked is complete.

Function
REQ-011 SHALL implement FSM states IDLE, BCH, SCAN, FMT_WRITE; any illegal state returns to IDLE.
REQ-012 SHALL, at edge E0 (IDLE and start_mask=1), capture qr_plain, mask_id and ec_level into internal registers, then enter BCH; later input changes have no effect.
REQ-013 SHALL, in BCH, compute the 15-bit format word over 5 edges (E1-E5) as {ec_level,mask_id} followed by the 10-bit remainder of division by generator 0x537, one division step per edge.
REQ-014 SHALL, in SCAN, visit one module per edge over E6-E446 (441 edges), x fastest, then y, starting from address 0.
REQ-015 SHALL classify a module as function if (row<=8 and col<=8) or (row<=8 and col>=13) or (row>=13 and col<=8) or row==6 or col==6; all other modules are data.
REQ-016 SHALL write qr_masked[addr] = captured bit XOR cond for data modules and the captured bit unchanged for function modules.
REQ-017 SHALL use cond per mask_id: 0 (r+c)%2==0; 1 r%2==0; 2 c%3==0; 3 (r+c)%3==0; 4 (r/2+c/3)%2==0; 5 (rc)%2+(rc)%3==0; 6 ((rc)%2+(rc)%3)%2==0; 7 ((r+c)%2+(rc)%3)%2==0.
REQ-018 SHALL, at E447 (FMT_WRITE), write the format word f. Dark bit (f=1) is stored as 0.
REQ-019 SHALL place copy 1: f[14:9] at row 8 cols 0-5; f[8] at (8,7); f[7] at (8,8); f[6] at (7,8); f[5:0] at rows 5..0 of col 8.
REQ-020 SHALL place copy 2: f[14:8] at rows 20..14 of col 8, and f[7:0] at row 8 cols 13..20.
REQ-021 SHALL force the dark module at (13,8) to 0.
REQ-022 SHALL assert mask_done for exactly one cycle following E447, then return to IDLE; start-to-done latency is 447 edges.
REQ-023 SHALL hold mask_busy=1 from E0 until E447; mask_busy=0 in the mask_done cycle.
REQ-024 SHALL ignore start_mask while mask_busy=1.
REQ-025 SHALL accept start_mask asserted during the mask_done cycle as a new E0 (back-to-back).
REQ-026 SHALL hold qr_masked stable from mask_done until the next E0; its content is undefined while mask_busy=1.

Reset
REQ-027 SHALL, on rst_in=1 at any edge including mid-encode, enter IDLE with qr_masked=0, mask_busy=0, mask_done=0, counters=0; no mask_done is produced for the aborted encode.

Configuration
REQ-028 SHALL honour macro QR_FMT_MASK_XOR_EN: when defined, f is the BCH word XOR 0x5412 (ISO-compliant).
REQ-029 SHALL, when QR_FMT_MASK_XOR_EN is undefined, use the raw BCH word so the in-house unmasker decodes mask bits directly.

Verification
REQ-030 SHALL check: ec_level=01, mask_id=0 -> format word 0x77C4 with the macro, 0x23D6 without.
REQ-031 SHALL check: qr_plain all 1s, mask 0, L -> qr_masked[420]=0, qr_masked[399]=1, qr_masked[54]=0 (macro defined) or 1 (macro undefined), dark module = 0.
REQ-032 SHALL check: start_mask at E0 -> mask_done pulses once after exactly 447 edges; a second start_mask at E100 is ignored.
REQ-033 SHALL check: rst_in at E200 -> all outputs 0, no mask_done; a fresh start completes normally.
REQ-034 SHALL check: for all 8 mask_id values, random qr_plain passed through qr_mask_encode then unmask yields qr_plain on data modules (macro undefined).
REQ-035 SHALL check: start_mask held high through mask_done -> back-to-back encodes with no idle gap.

Source files
------------

// File: rtl/qr_mask_encode.sv
// qr_mask_encode: applies one of the eight ISO data-mask patterns to a
// version-1 (21x21) QR matrix and writes both copies of the format word.
// Optional macro QR_FMT_MASK_XOR_EN: XOR the BCH format word with 0x5412
// (ISO-compliant); when undefined the raw BCH word is written.
module qr_mask_encode #(
    parameter int unsigned MOD_SIZE = 21
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         start_mask,
    input  logic [2:0]                   mask_id,
    input  logic [1:0]                   ec_level,
    input  logic [MOD_SIZE*MOD_SIZE-1:0] qr_plain,
    output logic [MOD_SIZE*MOD_SIZE-1:0] qr_masked,
    output logic                         mask_busy,
    output logic                         mask_done
);
    localparam int unsigned NBITS       = MOD_SIZE * MOD_SIZE;
    localparam logic [4:0]  LAST        = 5'(MOD_SIZE - 1);
    localparam logic [14:0] GEN_ALIGNED = 15'h537 << 4;

    typedef enum logic [1:0] {IDLE, BCH, SCAN, FMT_WRITE} state_t;
    state_t state, state_nxt;

    logic [NBITS-1:0] plain_q;
    logic [2:0]       mask_q;
    logic [1:0]       ec_q;
    logic [14:0]      bch_q;
    logic [2:0]       bch_cnt;
    logic [4:0]       x_cnt, y_cnt;

    logic [4:0]  row, col;
    logic [5:0]  sum_rc;
    logic [9:0]  prod;
    logic [1:0]  prod_m3, sum_m3, col_m3;
    logic        col_d3_odd;
    logic        is_func, cond, scan_bit;
    logic [14:0] fmt_word;

    // matrix address of (row, col): row = MOD_SIZE-1-x, col = y
    function automatic logic [8:0] addr_of(input int unsigned r, input int unsigned c);
        return 9'((MOD_SIZE - 1 - r) + c * MOD_SIZE);
    endfunction

    // state register
    always_ff @(posedge clk_in) begin
        if (rst_in) state <= IDLE;
        else        state <= state_nxt;
    end

    // next-state logic
    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE:      state_nxt = start_mask ? BCH : IDLE;
            BCH:       state_nxt = (bch_cnt == 3'd4) ? SCAN : BCH;
            SCAN:      state_nxt = (x_cnt == LAST && y_cnt == LAST) ? FMT_WRITE : SCAN;
            FMT_WRITE: state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // outputs decoded from state
    always_comb begin
        mask_busy = (state != IDLE);
    end

    // mask condition and module classification for the module under the scan counters
    always_comb begin
        row        = LAST - x_cnt;
        col        = y_cnt;
        sum_rc     = {1'b0, row} + {1'b0, col};
        prod       = {5'b0, row} * {5'b0, col};
        prod_m3    = 2'(prod % 10'd3);
        sum_m3     = 2'(sum_rc % 6'd3);
        col_m3     = 2'(col % 5'd3);
        col_d3_odd = ((col / 5'd3) & 5'd1) != 5'd0;
        is_func    = (row <= 5'd8 && col <= 5'd8) || (row <= 5'd8 && col >= 5'd13) ||
                     (row >= 5'd13 && col <= 5'd8) || row == 5'd6 || col == 5'd6;
        case (mask_q)
            3'd0:    cond = ~sum_rc[0];
            3'd1:    cond = ~row[0];
            3'd2:    cond = (col_m3 == 2'd0);
            3'd3:    cond = (sum_m3 == 2'd0);
            3'd4:    cond = ~(row[1] ^ col_d3_odd);
            3'd5:    cond = ~prod[0] & (prod_m3 == 2'd0);
            3'd6:    cond = ~(prod[0] ^ prod_m3[0]);
            default: cond = ~(sum_rc[0] ^ prod_m3[0]);
        endcase
        scan_bit = is_func ? plain_q[0] : (plain_q[0] ^ cond);
`ifdef QR_FMT_MASK_XOR_EN
        fmt_word = {ec_q, mask_q, bch_q[14:5]} ^ 15'h5412;
`else
        fmt_word = {ec_q, mask_q, bch_q[14:5]};
`endif
    end

    // datapath: capture, BCH division, masked scan and format overlay
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            qr_masked <= '0;
            plain_q   <= '0;
            mask_q    <= '0;
            ec_q      <= '0;
            bch_q     <= '0;
            bch_cnt   <= '0;
            x_cnt     <= '0;
            y_cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_mask) begin
                        plain_q <= qr_plain;
                        mask_q  <= mask_id;
                        ec_q    <= ec_level;
                        bch_q   <= {ec_level, mask_id, 10'b0};
                        bch_cnt <= '0;
                        x_cnt   <= '0;
                        y_cnt   <= '0;
                    end
                end
                BCH: begin
                    // one long-division step; remainder ends up in bch_q[14:5]
                    bch_q   <= (bch_q[14] ? (bch_q ^ GEN_ALIGNED) : bch_q) << 1;
                    bch_cnt <= bch_cnt + 3'd1;
                end
                SCAN: begin
                    // address 0 enters first and has shifted down to bit 0 after NBITS steps
                    qr_masked <= {scan_bit, qr_masked[NBITS-1:1]};
                    plain_q   <= plain_q >> 1;
                    if (x_cnt == LAST) begin
                        x_cnt <= '0;
                        y_cnt <= y_cnt + 5'd1;
                    end else begin
                        x_cnt <= x_cnt + 5'd1;
                    end
                end
                FMT_WRITE: begin
                    for (int unsigned i = 0; i < 6; i++) begin
                        qr_masked[addr_of(8, i)] <= ~fmt_word[4'(14 - i)];
                        qr_masked[addr_of(i, 8)] <= ~fmt_word[4'(i)];
                    end
                    qr_masked[addr_of(8, 7)] <= ~fmt_word[8];
                    qr_masked[addr_of(8, 8)] <= ~fmt_word[7];
                    qr_masked[addr_of(7, 8)] <= ~fmt_word[6];
                    for (int unsigned i = 0; i < 7; i++)
                        qr_masked[addr_of(14 + i, 8)] <= ~fmt_word[4'(8 + i)];
                    for (int unsigned i = 0; i < 8; i++)
                        qr_masked[addr_of(8, 13 + i)] <= ~fmt_word[4'(7 - i)];
                    qr_masked[addr_of(13, 8)] <= 1'b0;
                    x_cnt <= '0;
                    y_cnt <= '0;
                end
                default: ;
            endcase
        end
    end

    // completion pulse in the cycle after the format write
    always_ff @(posedge clk_in) begin
        if (rst_in) mask_done <= 1'b0;
        else        mask_done <= (state == FMT_WRITE);
    end

endmodule

// File: tb/tb_qr_mask_encode.sv
// tb_qr_mask_encode: directed bench for qr_mask_encode with a behavioural
// reference model; honours QR_FMT_MASK_XOR_EN the same way as the design.
module tb_qr_mask_encode;
    localparam int N = 441;

`ifdef QR_FMT_MASK_XOR_EN
    localparam int F_L0 = 'h77C4;
    localparam int F_M0 = 'h5412;
    localparam int B54  = 0;
`else
    localparam int F_L0 = 'h23D6;
    localparam int F_M0 = 'h0000;
    localparam int B54  = 1;
`endif

    logic         clk_in = 1'b0;
    logic         rst_in;
    logic         start_mask;
    logic [2:0]   mask_id;
    logic [1:0]   ec_level;
    logic [N-1:0] qr_plain;
    logic [N-1:0] qr_masked;
    logic         mask_busy;
    logic         mask_done;

    int errors = 0;
    int checks = 0;

    qr_mask_encode #(.MOD_SIZE(21)) dut (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .start_mask (start_mask),
        .mask_id    (mask_id),
        .ec_level   (ec_level),
        .qr_plain   (qr_plain),
        .qr_masked  (qr_masked),
        .mask_busy  (mask_busy),
        .mask_done  (mask_done)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic chk_vec(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [8:0] A(input int r, input int c);
        return 9'((20 - r) + 21 * c);
    endfunction

    function automatic bit is_func(input int r, input int c);
        return (r <= 8 && c <= 8) || (r <= 8 && c >= 13) || (r >= 13 && c <= 8) || r == 6 || c == 6;
    endfunction

    function automatic bit cond(input int m, input int r, input int c);
        case (m)
            0: return (r + c) % 2 == 0;
            1: return r % 2 == 0;
            2: return c % 3 == 0;
            3: return (r + c) % 3 == 0;
            4: return (r / 2 + c / 3) % 2 == 0;
            5: return (r * c) % 2 + (r * c) % 3 == 0;
            6: return ((r * c) % 2 + (r * c) % 3) % 2 == 0;
            default: return ((r + c) % 2 + (r * c) % 3) % 2 == 0;
        endcase
    endfunction

    function automatic logic [14:0] fmt_word(input logic [1:0] ec, input logic [2:0] m);
        int unsigned data, rem;
        logic [14:0] f;
        data = {27'd0, ec, m};
        rem  = data << 10;
        for (int b = 14; b >= 10; b--)
            if (((rem >> b) & 1) != 0) rem = rem ^ (32'h537 << (b - 10));
        f = 15'((data << 10) | rem);
`ifdef QR_FMT_MASK_XOR_EN
        f = f ^ 15'h5412;
`endif
        return f;
    endfunction

    function automatic logic [N-1:0] encode(input logic [N-1:0] p, input logic [2:0] m, input logic [1:0] ec);
        logic [N-1:0] o;
        logic [14:0]  f;
        int r, c;
        for (int a = 0; a < N; a++) begin
            r = 20 - (a % 21);
            c = a / 21;
            o[9'(a)] = is_func(r, c) ? p[9'(a)] : (p[9'(a)] ^ cond(int'(m), r, c));
        end
        f = fmt_word(ec, m);
        for (int i = 0; i < 6; i++) begin
            o[A(8, i)] = ~f[4'(14 - i)];
            o[A(i, 8)] = ~f[4'(i)];
        end
        o[A(8, 7)] = ~f[8];
        o[A(8, 8)] = ~f[7];
        o[A(7, 8)] = ~f[6];
        for (int k = 0; k < 7; k++) o[A(20 - k, 8)] = ~f[4'(14 - k)];
        for (int k = 0; k < 8; k++) o[A(8, 13 + k)] = ~f[4'(7 - k)];
        o[A(13, 8)] = 1'b0;
        return o;
    endfunction

    function automatic int get_f1(input logic [N-1:0] v);
        logic [14:0] f;
        for (int i = 0; i < 6; i++) begin
            f[4'(14 - i)] = ~v[A(8, i)];
            f[4'(i)]      = ~v[A(i, 8)];
        end
        f[8] = ~v[A(8, 7)];
        f[7] = ~v[A(8, 8)];
        f[6] = ~v[A(7, 8)];
        return int'(f);
    endfunction

    function automatic int get_f2(input logic [N-1:0] v);
        logic [14:0] f;
        for (int k = 0; k < 7; k++) f[4'(8 + k)] = ~v[A(14 + k, 8)];
        for (int k = 0; k < 8; k++) f[4'(7 - k)] = ~v[A(8, 13 + k)];
        return int'(f);
    endfunction

    // cycle-level model: remaining edges until completion, pending and visible result
    int           m_left = 0;
    bit           m_done = 0;
    logic [N-1:0] m_out  = '0;
    logic [N-1:0] m_pend = '0;
    bit           cmp_en = 0;

    always @(posedge clk_in) begin
        if (rst_in === 1'b1) begin
            m_left = 0;
            m_done = 0;
            m_out  = '0;
        end else begin
            m_done = 0;
            if (m_left == 0) begin
                if (start_mask === 1'b1) begin
                    m_pend = encode(qr_plain, mask_id, ec_level);
                    m_left = 447;
                end
            end else begin
                m_left--;
                if (m_left == 0) begin
                    m_done = 1;
                    m_out  = m_pend;
                end
            end
        end
    end

    always @(negedge clk_in) begin
        if (cmp_en) begin
            chk("busy", int'(mask_busy), int'(m_left != 0));
            chk("done", int'(mask_done), int'(m_done));
            if (m_left == 0) chk_vec("qr_masked", qr_masked, m_out);
        end
    end

    // ---------------- stimulus ----------------
    task automatic kick();
        @(negedge clk_in);
        start_mask = 1'b1;
        @(negedge clk_in);
        start_mask = 1'b0;
    endtask

    // start an encode; optionally pulse start again at edge extra_at
    task automatic run_encode(input int extra_at, input bit scramble, output int lat, output bit got);
        kick();
        if (scramble) begin
            qr_plain = ~qr_plain;
            mask_id  = mask_id + 3'd1;
            ec_level = ~ec_level;
        end
        lat = 0;
        got = 0;
        while (!got && lat < 1000) begin
            start_mask = (lat == extra_at - 1);
            @(negedge clk_in);
            lat++;
            if (mask_done === 1'b1) got = 1;
        end
        start_mask = 1'b0;
    endtask

    task automatic rand_plain();
        for (int i = 0; i < N; i++) qr_plain[9'(i)] = 1'($urandom_range(0, 1));
    endtask

    int           lat, cnt;
    bit           got;
    logic [N-1:0] saved;

    initial begin
        rst_in = 1'b1; start_mask = 1'b0; mask_id = '0; ec_level = '0; qr_plain = '0;
        repeat (3) @(negedge clk_in);
        chk("rst_busy", int'(mask_busy), 0);
        chk("rst_done", int'(mask_done), 0);
        chk_vec("rst_qr", qr_masked, '0);
        rst_in = 1'b0;
        cmp_en = 1;

        // all-white, mask 0, level L, extra start at E100 must be ignored
        qr_plain = '1; mask_id = 3'd0; ec_level = 2'b01;
        run_encode(100, 0, lat, got);
        chk("L0_done_seen", int'(got), 1);
        chk("L0_latency", lat, 447);
        chk("bit420", int'(qr_masked[420]), 0);
        chk("bit399", int'(qr_masked[399]), 1);
        chk("bit54", int'(qr_masked[54]), B54);
        chk("dark175", int'(qr_masked[175]), 0);
        chk("L0_fmt_copy1", get_f1(qr_masked), F_L0);
        chk("L0_fmt_copy2", get_f2(qr_masked), F_L0);
        @(negedge clk_in);
        chk("done_one_cycle", int'(mask_done), 0);
        repeat (5) @(negedge clk_in);

        // all-white, mask 0, level M
        mask_id = 3'd0; ec_level = 2'b00;
        run_encode(0, 0, lat, got);
        chk("M0_latency", lat, 447);
        chk("M0_fmt_copy1", get_f1(qr_masked), F_M0);
        chk("M0_fmt_copy2", get_f2(qr_masked), F_M0);

        // reset at E200 aborts the encode without a done pulse
        rand_plain(); mask_id = 3'd3; ec_level = 2'b11;
        kick();
        repeat (199) @(negedge clk_in);
        rst_in = 1'b1;
        @(negedge clk_in);
        rst_in = 1'b0;
        chk("abort_busy", int'(mask_busy), 0);
        chk("abort_done", int'(mask_done), 0);
        chk_vec("abort_qr", qr_masked, '0);
        cnt = 0;
        repeat (500) begin
            @(negedge clk_in);
            if (mask_done === 1'b1) cnt++;
        end
        chk("abort_no_done", cnt, 0);
        run_encode(0, 0, lat, got);
        chk("after_abort_latency", lat, 447);

        // every mask on random data; inputs scrambled after E0 must not matter
        for (int m = 0; m < 8; m++) begin
            rand_plain();
            saved    = qr_plain;
            mask_id  = 3'(m);
            ec_level = 2'(m);
            run_encode(0, 1, lat, got);
            chk($sformatf("m%0d_latency", m), lat, 447);
            cnt = 0;
            for (int a = 0; a < N; a++) begin
                if (!is_func(20 - a % 21, a / 21) &&
                    ((qr_masked[9'(a)] ^ cond(m, 20 - a % 21, a / 21)) !== saved[9'(a)]))
                    cnt++;
            end
            chk($sformatf("m%0d_unmask", m), cnt, 0);
        end

        // start held high through mask_done gives back-to-back encodes
        rand_plain(); mask_id = 3'd6; ec_level = 2'b10;
        @(negedge clk_in);
        start_mask = 1'b1;
        got = 0;
        cnt = 0;
        while (!got && cnt < 1000) begin
            @(negedge clk_in);
            cnt++;
            if (mask_done === 1'b1) got = 1;
        end
        chk("b2b_first_done", int'(got), 1);
        rand_plain(); mask_id = 3'd5;
        @(negedge clk_in);
        chk("b2b_no_gap", int'(mask_busy), 1);
        start_mask = 1'b0;
        lat = 1;
        got = 0;
        while (!got && lat < 1000) begin
            @(negedge clk_in);
            lat++;
            if (mask_done === 1'b1) got = 1;
        end
        chk("b2b_period", lat, 448);

        repeat (3) @(negedge clk_in);
        cmp_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
